chacha_qr_seq: RTL and testbench

Sequencer that executes one ChaCha quarter-round on four 32-bit state words by driving a single-step add/xor/rotate datapath through its four operations, ad0 → bc0 → ad1 → bc1. Words are accepted and returned over valid/ready handshakes and held in internal registers between steps. The block sits between the core's ChaCha accelerator front-end (or a block-function scheduler) and the shared step datapath, so one datapath instance serves a complete quarter-round.

---
 rtl/chacha_pkg.sv | 32 +++
 rtl/chacha_qr_dp.sv | 41 ++++
 rtl/chacha_qr_seq.sv | 147 ++++++++++++++
 tb/tb_chacha_qr_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// chacha_pkg
// Shared definitions for the ChaCha quarter-round sequencer and its
// single-step datapath:
//   - FSM state encoding (IDLE, AD0, BC0, AD1, BC1, DONE)
//   - one-hot step op encoding (ad0/bc0/ad1/bc1)
//   - per-step rotate-left amounts 16/12/8/7
//   - rol32 helper (32-bit rotate-left by a 5-bit amount)
package chacha_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AD0  = 3'd1;
  localparam logic [2:0] ST_BC0  = 3'd2;
  localparam logic [2:0] ST_AD1  = 3'd3;
  localparam logic [2:0] ST_BC1  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [3:0] OP_AD0 = 4'b0001;
  localparam logic [3:0] OP_BC0 = 4'b0010;
  localparam logic [3:0] OP_AD1 = 4'b0100;
  localparam logic [3:0] OP_BC1 = 4'b1000;

  localparam logic [4:0] ROT_AD0 = 5'd16;
  localparam logic [4:0] ROT_BC0 = 5'd12;
  localparam logic [4:0] ROT_AD1 = 5'd8;
  localparam logic [4:0] ROT_BC1 = 5'd7;

  // A zero amount shifts right by 32, which yields 0, so the result is x.
  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/chacha_qr_dp.sv
// chacha_qr_dp
// Combinational single-step ChaCha add/xor/rotate datapath.
// Ports:
//   rs1 [63:0] in  : {a, d}
//   rs2 [63:0] in  : {b, c}
//   op  [3:0]  in  : one-hot step select (OP_AD0/OP_BC0/OP_AD1/OP_BC1)
//   rd  [63:0] out : ad steps -> {new a, new d}; bc steps -> {new b, new c}
module chacha_qr_dp
  import chacha_pkg::*;
(
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  input  logic [3:0]  op,
  output logic [63:0] rd
);

  logic        is_ad;
  logic [4:0]  rot;
  logic [31:0] sum;

  always_comb begin
    rot = ROT_BC1;
    case (op)
      OP_AD0:  rot = ROT_AD0;
      OP_BC0:  rot = ROT_BC0;
      OP_AD1:  rot = ROT_AD1;
      OP_BC1:  rot = ROT_BC1;
      default: rot = ROT_BC1;
    endcase
  end

  assign is_ad = (op == OP_AD0) || (op == OP_AD1);

  // ad steps add a+b (upper halves); bc steps add c+d (lower halves).
  assign sum = is_ad ? (rs1[63:32] + rs2[63:32]) : (rs1[31:0] + rs2[31:0]);

  // The sum goes to a (ad) or c (bc); the rotated xor goes to d (ad) or b (bc).
  assign rd = is_ad ? {sum, rol32(sum ^ rs1[31:0], rot)}
                    : {rol32(sum ^ rs2[63:32], rot), sum};

endmodule

// File: rtl/chacha_qr_seq.sv
// chacha_qr_seq
// Runs one ChaCha quarter-round on words a,b,c,d by stepping a shared
// add/xor/rotate datapath through ad0 -> bc0 -> ad1 -> bc1.
// Ports:
//   g_clk, g_resetn            : clock, async active-low reset
//   req_valid/req_ready        : request handshake, req_a..req_d input words
//   rsp_valid/rsp_ready        : response handshake, rsp_a..rsp_d result words
//   busy                       : high whenever not IDLE
//   req_iter [3:0]             : extra quarter-round repetitions
//                                (only when CHACHA_QR_ITER_EN is defined)
// Optional feature macro: CHACHA_QR_ITER_EN
module chacha_qr_seq
  import chacha_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_c,
  input  logic [31:0] req_d,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_a,
  output logic [31:0] rsp_b,
  output logic [31:0] rsp_c,
  output logic [31:0] rsp_d,
  output logic        busy
`ifdef CHACHA_QR_ITER_EN
  ,
  input  logic [3:0]  req_iter
`endif
);

  logic [2:0]  state;
  logic [31:0] a, b, c, d;
  logic [3:0]  op;
  logic [63:0] rd;
  logic        accept;
  logic        repeat_qr;

  assign req_ready = (state == ST_IDLE) || ((state == ST_DONE) && rsp_ready);
  assign rsp_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid && req_ready;

  assign rsp_a = a;
  assign rsp_b = b;
  assign rsp_c = c;
  assign rsp_d = d;

  always_comb begin
    op = 4'b0000;
    case (state)
      ST_AD0:  op = OP_AD0;
      ST_BC0:  op = OP_BC0;
      ST_AD1:  op = OP_AD1;
      ST_BC1:  op = OP_BC1;
      default: op = 4'b0000;
    endcase
  end

  chacha_qr_dp u_dp (
    .rs1 ({a, d}),
    .rs2 ({b, c}),
    .op  (op),
    .rd  (rd)
  );

`ifdef CHACHA_QR_ITER_EN
  logic [3:0] iter_cnt;

  // Remaining extra passes; loaded on accept, consumed at the end of each BC1.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      iter_cnt <= 4'd0;
    end else if (accept) begin
      iter_cnt <= req_iter;
    end else if ((state == ST_BC1) && (iter_cnt != 4'd0)) begin
      iter_cnt <= iter_cnt - 4'd1;
    end
  end

  assign repeat_qr = (iter_cnt != 4'd0);
`else
  assign repeat_qr = 1'b0;
`endif

  // DONE with rsp_ready and req_valid reloads directly, giving 5-cycle throughput.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= ST_IDLE;
      a     <= 32'd0;
      b     <= 32'd0;
      c     <= 32'd0;
      d     <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a     <= req_a;
            b     <= req_b;
            c     <= req_c;
            d     <= req_d;
            state <= ST_AD0;
          end
        end
        ST_AD0: begin
          a     <= rd[63:32];
          d     <= rd[31:0];
          state <= ST_BC0;
        end
        ST_BC0: begin
          b     <= rd[63:32];
          c     <= rd[31:0];
          state <= ST_AD1;
        end
        ST_AD1: begin
          a     <= rd[63:32];
          d     <= rd[31:0];
          state <= ST_BC1;
        end
        ST_BC1: begin
          b     <= rd[63:32];
          c     <= rd[31:0];
          state <= repeat_qr ? ST_AD0 : ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            if (req_valid) begin
              a     <= req_a;
              b     <= req_b;
              c     <= req_c;
              d     <= req_d;
              state <= ST_AD0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_qr_seq.sv
// tb_chacha_qr_seq
// Self-checking bench for chacha_qr_seq: directed RFC 7539 vector, probe
// after the first step, back-to-back throughput, backpressure, reset in
// flight, and randomized requests against a behavioural quarter-round model.
// With CHACHA_QR_ITER_EN defined, also checks a two-pass request.
module tb_chacha_qr_seq;

  logic        g_clk;
  logic        g_resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a, req_b, req_c, req_d;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_a, rsp_b, rsp_c, rsp_d;
  logic        busy;
`ifdef CHACHA_QR_ITER_EN
  logic [3:0]  req_iter;
`endif

  int nVectors;
  int nMiscompares;

  chacha_qr_seq dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_d     (req_d),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_a     (rsp_a),
    .rsp_b     (rsp_b),
    .rsp_c     (rsp_c),
    .rsp_d     (rsp_d),
    .busy      (busy)
`ifdef CHACHA_QR_ITER_EN
    ,
    .req_iter  (req_iter)
`endif
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Reference quarter-round written the way RFC 7539 states it.
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] quarterRound(input logic [127:0] w);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = w;
    a = a + b; d = d ^ a; d = rotl(d, 16);
    c = c + d; b = b ^ c; b = rotl(b, 12);
    a = a + b; d = d ^ a; d = rotl(d, 8);
    c = c + d; b = b ^ c; b = rotl(b, 7);
    return {a, b, c, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkWords(input string tag, input logic [127:0] expected);
    checkOutput({tag, ".a"}, rsp_a, expected[127:96]);
    checkOutput({tag, ".b"}, rsp_b, expected[95:64]);
    checkOutput({tag, ".c"}, rsp_c, expected[63:32]);
    checkOutput({tag, ".d"}, rsp_d, expected[31:0]);
  endtask

  // Called at a negedge with req_ready expected high; returns at the negedge
  // after the accepting edge.
  task automatic applyStimulus(input logic [127:0] w);
    {req_a, req_b, req_c, req_d} = w;
    req_valid = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    req_valid = 1'b0;
  endtask

  task automatic waitResponse(input int start, output int cycles);
    cycles = start;
    while (!rsp_valid && cycles < 64) begin
      @(negedge g_clk);
      cycles++;
    end
    if (!rsp_valid) checkOutput("rsp_timeout", 32'd0, 32'd1);
  endtask

  localparam logic [127:0] RFC_IN  = {32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567};
  localparam logic [127:0] RFC_OUT = {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};

  initial begin
    int cycles;
    logic [127:0] w, expected, junk;
    int stall;

    nVectors = 0;
    nMiscompares = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    {req_a, req_b, req_c, req_d} = '0;
`ifdef CHACHA_QR_ITER_EN
    req_iter = 4'd0;
`endif
    g_resetn = 1'b1;
    #1 g_resetn = 1'b0;
    #1;
    checkOutput("reset.req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkWords("reset", 128'd0);
    #21 g_resetn = 1'b1;
    @(negedge g_clk);

    // Model sanity against the published vector.
    checkOutput("model.rfc_a", quarterRound(RFC_IN) >> 96, RFC_OUT >> 96);

    // RFC vector with a probe after the first step.
    applyStimulus(RFC_IN);
    @(negedge g_clk);
    checkWords("rfc_ad0", {32'h12131415, 32'h01020304, 32'h9b8d6f43, 32'h51721330});
    waitResponse(1, cycles);
    checkOutput("rfc.latency", cycles, 32'd4);
    checkWords("rfc", RFC_OUT);
    @(negedge g_clk);
    checkOutput("rfc.idle", {31'd0, busy}, 32'd0);

    // All-zero then all-ones back to back.
    applyStimulus(128'd0);
    waitResponse(0, cycles);
    checkOutput("zero.latency", cycles, 32'd4);
    checkWords("zero", 128'd0);
    checkOutput("b2b.req_ready", {31'd0, req_ready}, 32'd1);
    applyStimulus({128{1'b1}});
    waitResponse(1, cycles);
    checkOutput("b2b.gap", cycles, 32'd5);
    checkWords("ones", quarterRound({128{1'b1}}));
    @(negedge g_clk);

    // Backpressure: 10 cycles in DONE with rsp_ready low.
    rsp_ready = 1'b0;
    applyStimulus(RFC_IN);
    waitResponse(0, cycles);
    checkOutput("bp.latency", cycles, 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge g_clk);
      checkOutput("bp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp.req_ready", {31'd0, req_ready}, 32'd0);
      checkWords("bp", RFC_OUT);
    end
    rsp_ready = 1'b1;
    #1 checkOutput("bp.release", {31'd0, req_ready}, 32'd1);
    @(negedge g_clk);
    checkOutput("bp.idle", {31'd0, busy}, 32'd0);

    // Reset while in BC0 discards the quarter-round.
    applyStimulus(RFC_IN);
    @(negedge g_clk);
    checkOutput("rst.busy_before", {31'd0, busy}, 32'd1);
    #2 g_resetn = 1'b0;
    #1;
    checkOutput("rst.req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst.busy", {31'd0, busy}, 32'd0);
    checkWords("rst", 128'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);
    checkOutput("rst.no_rsp", {31'd0, rsp_valid}, 32'd0);
    applyStimulus(RFC_IN);
    waitResponse(0, cycles);
    checkOutput("rst.rfc_latency", cycles, 32'd4);
    checkWords("rst.rfc", RFC_OUT);
    @(negedge g_clk);

    // Random requests; junk requests while busy must be ignored.
    for (int n = 0; n < 20; n++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      expected = quarterRound(w);
      stall = $urandom_range(0, 3);
      rsp_ready = 1'b0;
      applyStimulus(w);
      cycles = 0;
      while (!rsp_valid && cycles < 64) begin
        junk = {$urandom, $urandom, $urandom, $urandom};
        {req_a, req_b, req_c, req_d} = junk;
        req_valid = $urandom_range(0, 1) == 1;
        @(negedge g_clk);
        cycles++;
      end
      req_valid = 1'b0;
      if (!rsp_valid) checkOutput("rand.timeout", 32'd0, 32'd1);
      checkOutput("rand.latency", cycles, 32'd4);
      checkWords("rand", expected);
      for (int s = 0; s < stall; s++) begin
        @(negedge g_clk);
        checkWords("rand.hold", expected);
      end
      rsp_ready = 1'b1;
      @(negedge g_clk);
      checkOutput("rand.idle", {31'd0, busy}, 32'd0);
    end

`ifdef CHACHA_QR_ITER_EN
    req_iter = 4'd1;
    applyStimulus(RFC_IN);
    req_iter = 4'd0;
    waitResponse(0, cycles);
    checkOutput("iter.latency", cycles, 32'd8);
    checkWords("iter", quarterRound(quarterRound(RFC_IN)));
    @(negedge g_clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
